// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with valid/ready handshake, flush,
// stage-indexed stall and a saturating bubble counter. Define PIPE_SKID_BUF_EN
// to add a second (skid) entry and a registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int WE_W   = 3,
  parameter int STAGE  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WE_W-1:0]   in_we,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WE_W-1:0]   out_we,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [WE_W-1:0]   we;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t in_e;
  entry_t m_e;
  logic   m_v;
  logic   push;
  logic   pop;
  logic   stall_up;
  logic   stall_dn;

  assign in_e     = '{we: in_we, data: in_data};
  assign stall_up = stall[STAGE];
  assign stall_dn = stall[STAGE+1];

  assign push = in_valid & in_ready & ~stall_up & ~flush;
  assign pop  = m_v & out_ready & ~stall_dn;

`ifdef PIPE_SKID_BUF_EN
  entry_t s_e;
  logic   s_v;

  assign in_ready = ~s_v;
  assign occ      = {1'b0, m_v} + {1'b0, s_v};

  // NOTE: payload registers are reset too, since flush must zero them and
  // reset shares the same clear path; non-blocking assignments throughout.
  always_ff @(posedge clk) begin
    if (resetn || flush) begin
      m_v <= 1'b0;
      m_e <= '0;
      s_v <= 1'b0;
      s_e <= '0;
    end else if (m_v && s_v) begin
      if (pop) begin
        m_e <= s_e;
        s_v <= 1'b0;
      end
    end else if (m_v) begin
      if (push && pop) begin
        m_e <= in_e;
      end else if (push) begin
        s_v <= 1'b1;
        s_e <= in_e;
      end else if (pop) begin
        m_v <= 1'b0;
      end
    end else if (push) begin
      m_v <= 1'b1;
      m_e <= in_e;
    end
  end
`else
  assign in_ready = ~m_v | (out_ready & ~stall_dn);
  assign occ      = {1'b0, m_v};

  // NOTE: payload registers are reset too, since flush must zero them and
  // reset shares the same clear path; non-blocking assignments throughout.
  always_ff @(posedge clk) begin
    if (resetn || flush) begin
      m_v <= 1'b0;
      m_e <= '0;
    end else if (push) begin
      // A push while full only happens together with a pop (in_ready).
      m_v <= 1'b1;
      m_e <= in_e;
    end else if (pop) begin
      m_v <= 1'b0;
    end
  end
`endif

  // A drained head keeps its stale payload; mask so bubbles read as zero.
  assign out_valid = m_v;
  assign out_we    = m_v ? m_e.we   : '0;
  assign out_data  = m_v ? m_e.data : '0;

  always_ff @(posedge clk) begin
    if (resetn) begin
      bubble_cnt <= '0;
    end else if (!m_v && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  logic unused_stall;
  assign unused_stall = ^stall;

endmodule
